// File: rtl/pe_row_acc.sv
// pe_row_acc: one processing-element row. LANES signed multiplies feed an
// adder tree and a dot-product accumulator over a 3-stage pipeline
// (S1 products, S2 tree sum, S3 accumulator/result).
// Optional build macro PE_ROW_ACC_SAT_EN: the S3 addition saturates and a
// sat_flag output marks results in which any tile saturated. Without it the
// accumulator wraps two's complement at ACC_BW.
module pe_row_acc #(
  parameter int DATA_BW        = 8,
  parameter int WEIGHT_BW      = 8,
  parameter int LANES          = 8,
  parameter int PARTIAL_MUL_BW = 16,
  parameter int ACC_BW         = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_load_valid,
  output logic                          w_load_ready,
  input  logic [WEIGHT_BW*LANES-1:0]    w_load_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [DATA_BW*LANES-1:0]      data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_BW-1:0]      data_out,
  output logic                          busy
`ifdef PE_ROW_ACC_SAT_EN
  ,
  output logic                          sat_flag
`endif
);

  logic signed [WEIGHT_BW-1:0]      wgt     [LANES];
  logic signed [PARTIAL_MUL_BW-1:0] prod_c  [LANES];
  logic signed [PARTIAL_MUL_BW-1:0] prod_p1 [LANES];
  logic                             vld_p1, last_p1;
  logic signed [ACC_BW-1:0]         tree_sum;
  logic signed [ACC_BW-1:0]         sum_p2;
  logic                             vld_p2, last_p2;
  logic signed [ACC_BW-1:0]         acc;
  logic signed [ACC_BW-1:0]         acc_next;
  logic                             acc_open;
  logic                             adv, w_take, in_take, s3_fire;
`ifdef PE_ROW_ACC_SAT_EN
  logic                             sat_now, sat_acc;
`endif

  // Full-precision signed product, sign-extended to the registered lane width.
  function automatic logic signed [PARTIAL_MUL_BW-1:0] mul_ext(
    input logic signed [DATA_BW-1:0]   a,
    input logic signed [WEIGHT_BW-1:0] b
  );
    logic signed [DATA_BW+WEIGHT_BW-1:0] p;
    p = a * b;
    return PARTIAL_MUL_BW'(p);
  endfunction

`ifdef PE_ROW_ACC_SAT_EN
  // Saturating add; MSB of the return value is the overflow indication.
  function automatic logic [ACC_BW:0] sat_add(
    input logic signed [ACC_BW-1:0] a,
    input logic signed [ACC_BW-1:0] b
  );
    logic [ACC_BW:0] w;
    w = {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
    if (w[ACC_BW] != w[ACC_BW-1]) begin
      if (w[ACC_BW]) return {1'b1, 1'b1, {(ACC_BW-1){1'b0}}};
      else           return {1'b1, 1'b0, {(ACC_BW-1){1'b1}}};
    end
    return {1'b0, w[ACC_BW-1:0]};
  endfunction
`endif

  // Handshake: the whole pipe advances only when the result slot can move.
  // A weight load is allowed only with no tile anywhere in flight, and it
  // takes priority over an activation offered in the same cycle.
  always_comb begin
    adv          = !out_valid || out_ready;
    busy         = vld_p1 || vld_p2 || acc_open;
    w_load_ready = !busy;
    w_take       = w_load_valid && w_load_ready;
    in_ready     = adv && !w_take;
    in_take      = in_valid && in_ready;
    s3_fire      = adv && vld_p2;
  end

  // Lane products from the incoming activation and the held weights.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = mul_ext(data_in[i*DATA_BW +: DATA_BW], wgt[i]);
    end
  end

  // Adder tree over the registered lane products.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + ACC_BW'(prod_p1[i]);
    end
  end

  // Accumulator update value for the tile sitting in S2.
  always_comb begin
`ifdef PE_ROW_ACC_SAT_EN
    logic [ACC_BW:0] r;
    r        = sat_add(acc, sum_p2);
    acc_next = r[ACC_BW-1:0];
    sat_now  = r[ACC_BW];
`else
    acc_next = acc + sum_p2;
`endif
  end

  // Weight register: all lanes replaced in one accepted load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) wgt[i] <= '0;
    end else if (w_take) begin
      for (int i = 0; i < LANES; i++) wgt[i] <= w_load_data[i*WEIGHT_BW +: WEIGHT_BW];
    end
  end

  // ---- S1: lane products ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_p1[i] <= '0;
    end else if (adv) begin
      vld_p1  <= in_take;
      last_p1 <= in_last;
      for (int i = 0; i < LANES; i++) prod_p1[i] <= prod_c[i];
    end
  end

  // ---- S2: tree sum ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      sum_p2  <= '0;
    end else if (adv) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      sum_p2  <= tree_sum;
    end
  end

  // ---- S3: accumulator and result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_open  <= 1'b0;
      data_out  <= '0;
      out_valid <= 1'b0;
`ifdef PE_ROW_ACC_SAT_EN
      sat_acc   <= 1'b0;
      sat_flag  <= 1'b0;
`endif
    end else begin
      if (s3_fire) begin
        if (last_p2) begin
          // Result leaves and the accumulator restarts in the same cycle.
          data_out <= acc_next;
          acc      <= '0;
          acc_open <= 1'b0;
`ifdef PE_ROW_ACC_SAT_EN
          sat_flag <= sat_acc || sat_now;
          sat_acc  <= 1'b0;
`endif
        end else begin
          acc      <= acc_next;
          acc_open <= 1'b1;
`ifdef PE_ROW_ACC_SAT_EN
          sat_acc  <= sat_acc || sat_now;
`endif
        end
      end
      if (s3_fire && last_p2) out_valid <= 1'b1;
      else if (out_ready)     out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_row_acc.sv
// Self-checking bench for pe_row_acc. Two instances share stimulus: the
// default 32-bit accumulator and a 16-bit one that exposes wrap-around.
// A transaction-level model (exact integer dot products, queue of results)
// is scored on every consumed result; directed cases pin literal values.
module tb_pe_row_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_load_valid;
  logic [63:0] w_load_data;
  logic        in_valid, in_last;
  logic [63:0] data_in;
  logic        out_ready;

  logic               w_load_ready, in_ready, out_valid, busy;
  logic signed [31:0] data_out;
  logic               w_load_ready16, in_ready16, out_valid16, busy16;
  logic signed [15:0] data_out16;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  longint      expq[$];
  longint      open_sum  = 0;
  int          open_cnt  = 0;
  logic [63:0] mw        = '0;
  int          n_push    = 0;
  int          n_pop     = 0;
  bit          hold_prev = 1'b0;
  logic signed [31:0] prev_dout;

  always #5 clk = ~clk;

  pe_row_acc u_dut (
    .clk(clk), .rst(rst),
    .w_load_valid(w_load_valid), .w_load_ready(w_load_ready), .w_load_data(w_load_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  pe_row_acc #(.ACC_BW(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .w_load_valid(w_load_valid), .w_load_ready(w_load_ready16), .w_load_data(w_load_data),
    .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last), .data_in(data_in),
    .out_valid(out_valid16), .out_ready(out_ready), .data_out(data_out16), .busy(busy16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrapn(input longint v, input int n);
    longint m;
    m = v & ((64'sd1 <<< n) - 1);
    if (m >= (64'sd1 <<< (n - 1))) m = m - (64'sd1 <<< n);
    return m;
  endfunction

  function automatic longint dot(input logic [63:0] a, input logic [63:0] w);
    longint s = 0;
    for (int i = 0; i < 8; i++) begin
      logic signed [7:0] x, y;
      x = a[i*8 +: 8];
      y = w[i*8 +: 8];
      s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  function automatic logic [63:0] splat(input int v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v);
    return r;
  endfunction

  // Monitor: invariants, model update on accepted transfers, result scoring.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      open_sum  = 0;
      open_cnt  = 0;
      mw        = '0;
      hold_prev = 1'b0;
    end else begin
      chk("wready_is_not_busy", w_load_ready, !busy);
      chk("in_ready_match16", in_ready16, in_ready);
      chk("out_valid_match16", out_valid16, out_valid);
      chk("busy_match16", busy16, busy);
      if (out_valid && !out_ready) chk("in_ready_while_stalled", in_ready, 0);
      if (hold_prev) begin
        chk("held_out_valid", out_valid, 1);
        chk("held_data_out", data_out, prev_dout);
      end
      hold_prev = out_valid && !out_ready;
      prev_dout = data_out;
      if (w_load_valid && w_load_ready) begin
        chk("load_excludes_input", in_ready, 0);
        mw = w_load_data;
      end
      if (in_valid && in_ready) begin
        open_sum += dot(data_in, mw);
        open_cnt++;
        if (in_last) begin
          expq.push_back(open_sum);
          n_push++;
          open_sum = 0;
          open_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          longint e;
          e = expq.pop_front();
          n_pop++;
          chk("result32", data_out, wrapn(e, 32));
          chk("result16", data_out16, wrapn(e, 16));
        end
      end
    end
  end

  task automatic load_w(input logic [63:0] w);
    int n = 0;
    w_load_data  = w;
    w_load_valid = 1'b1;
    @(negedge clk);
    while (!w_load_ready && n < 200) begin n++; @(negedge clk); end
    chk("load_w_accepted", w_load_ready, 1);
    @(posedge clk); #1;
    w_load_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] d, input bit last, output int stalls);
    stalls   = 0;
    data_in  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin stalls++; @(negedge clk); end
    chk("send_vec_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(output longint d32, output longint d16);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    chk("wait_result_seen", out_valid, 1);
    d32 = data_out;
    d16 = data_out16;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid     = 1'b0;
    w_load_valid = 1'b0;
    out_ready    = 1'b1;
    @(negedge clk);
    while ((busy || out_valid) && n < 300) begin n++; @(negedge clk); end
    chk("drain_idle", busy || out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot, pulses, nw;
    longint r32, r16, v;
    logic [63:0] ramp;

    rst = 1'b1; w_load_valid = 0; w_load_data = '0;
    in_valid = 0; in_last = 0; data_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_w_load_ready", w_load_ready, 1);
    @(posedge clk); #1;

    // single-tile dot product, latency T+3
    load_w(splat(1));
    send_vec(splat(2), 1, st);
    chk("lat_after_T", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_T+2", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_T+3_valid", out_valid, 1);
    chk("lat_T+3_data", data_out, 16);
    @(posedge clk); #1;

    // three back-to-back tiles, weights = lane index
    for (int i = 0; i < 8; i++) ramp[i*8 +: 8] = 8'(i);
    load_w(ramp);
    tot = 0;
    send_vec(splat(1), 0, st); tot += st;
    send_vec(splat(1), 0, st); tot += st;
    send_vec(splat(1), 1, st); tot += st;
    pulses = 0; v = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) begin pulses++; v = data_out; end
    end
    @(posedge clk); #1;
    chk("b2b_no_stall", tot, 0);
    chk("b2b_single_pulse", pulses, 1);
    chk("b2b_value", v, 84);

    // weight load wins over simultaneous activation while idle
    w_load_data = splat(3); w_load_valid = 1'b1;
    data_in = splat(1); in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("collide_in_ready", in_ready, 0);
    chk("collide_w_ready", w_load_ready, 1);
    @(posedge clk); #1;
    w_load_valid = 1'b0;
    @(negedge clk);
    chk("after_load_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(r32, r16);
    chk("new_weights_used", r32, 24);

    // weight load blocked while a dot product is open
    send_vec(splat(1), 0, st);
    w_load_data = splat(1); w_load_valid = 1'b1;
    @(negedge clk);
    chk("open_blocks_load", w_load_ready, 0);
    @(posedge clk); #1;
    send_vec(splat(1), 1, st);
    nw = 0;
    @(negedge clk);
    while (!w_load_ready && nw < 20) begin nw++; @(negedge clk); end
    chk("load_released", w_load_ready, 1);
    chk("load_release_result_valid", out_valid, 1);
    chk("load_release_result", data_out, 48);
    @(posedge clk); #1;
    w_load_valid = 1'b0;

    // backpressure: stuck consumer, keep offering last tiles
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_last = 1'b1; data_in = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    chk("bp_none_lost", n_pop, n_push);

    // long accumulation: wraps at 16 bits, exact at 32
    load_w(splat(127));
    for (int k = 0; k < 9; k++) send_vec(splat(-128), 0, st);
    send_vec(splat(-128), 1, st);
    wait_result(r32, r16);
    chk("long_acc32", r32, -1300480);
    chk("long_acc16_wrap", r16, 10240);

    // reset in the middle of a dot product
    load_w(splat(1));
    send_vec(splat(5), 0, st);
    send_vec(splat(5), 0, st);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_data_out16", data_out16, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_w_ready", w_load_ready, 1);
    send_vec(splat(1), 1, st);
    wait_result(r32, r16);
    chk("weights_cleared_by_reset", r32, 0);
    load_w(splat(1));
    send_vec(splat(1), 1, st);
    wait_result(r32, r16);
    chk("after_reset_result", r32, 8);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      in_last      = ($urandom_range(0, 3) == 0);
      data_in      = {$urandom, $urandom};
      out_ready    = ($urandom_range(0, 9) < 7);
      w_load_valid = ($urandom_range(0, 29) == 0);
      w_load_data  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; w_load_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    if (open_cnt > 0) send_vec({$urandom, $urandom}, 1, st);
    drain();
    chk("final_queue_empty", expq.size(), 0);
    chk("final_counts", n_pop, n_push);
    chk("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_row_acc.md
PE_ROW_ACC -- requirements
Module: pe_row_acc

Interface
REQ-001 DATA_BW, 8, signed activation width per lane.
REQ-002 WEIGHT_BW, 8, signed weight width per lane.
REQ-003 LANES, 8, number of multiply lanes (power of two, >=2).
REQ-004 PARTIAL_MUL_BW, 16, registered product width per lane (>= DATA_BW+WEIGHT_BW).
REQ-005 ACC_BW, 32, accumulator and result width (>= PARTIAL_MUL_BW+log2(LANES)).
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 w_load_valid  in  1  weight vector offered.
REQ-009 w_load_ready  out  1  weight vector accepted this cycle when high with w_load_valid.
REQ-010 w_load_data  in  WEIGHT_BW*LANES  signed weights, lane i at bits [i*WEIGHT_BW +: WEIGHT_BW].
REQ-011 in_valid  in  1  activation vector offered.
REQ-012 in_ready  out  1  activation vector accepted when high with in_valid.
REQ-013 in_last  in  1  qualifies the accepted vector as final tile of a dot product.
REQ-014 data_in  in  DATA_BW*LANES  signed activations, lane i at bits [i*DATA_BW +: DATA_BW].
REQ-015 out_valid  out  1  result held on data_out.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 data_out  out  ACC_BW  signed dot-product result.
REQ-018 busy  out  1  high while any pipeline stage is valid or a partial accumulation is open.

Function
REQ-019 Pipeline SHALL be 3 stages: S1 lane products registered (sign-extended to PARTIAL_MUL_BW); S2 adder-tree sum registered (sign-extended to ACC_BW); S3 accumulator/result register.
REQ-020 A vector accepted with in_last=1 at cycle T SHALL raise out_valid at T+3 absent stalls; result = accumulator + S2 sum, including all earlier non-last tiles since previous last.
REQ-021 A non-last tile SHALL add its sum into the accumulator and produce no output.
REQ-022 On a last tile reaching S3, accumulator SHALL be loaded into data_out and cleared to 0 in the same cycle, so a following tile starts a fresh dot product with no bubble.
REQ-023 Advance enable adv = !out_valid || out_ready; when adv=0 all stages and accumulator SHALL hold; in_ready = adv && !(w_load_valid && w_load_ready).
REQ-024 out_valid SHALL fall on out_valid&&out_ready unless a new last tile completes that cycle, in which case out_valid stays 1 with the new value.
REQ-025 w_load_ready SHALL be high only when busy=0; an accepted load SHALL update all LANES weights in one cycle, used by vectors accepted from the next cycle.
REQ-026 Simultaneous w_load_valid and in_valid while idle: weight load SHALL win; in_ready=0 that cycle.
REQ-027 out_valid pending with busy=0 SHALL not block weight load.
REQ-028 Without saturation, accumulation SHALL wrap two's complement at ACC_BW.

Reset
REQ-029 rst high SHALL asynchronously clear weights, all stage valids, products, sums, accumulator, data_out to 0 and out_valid to 0.
REQ-030 After reset release: in_ready=1, w_load_ready=1, busy=0.
REQ-031 Reset mid-dot-product SHALL discard the open accumulation; no result emitted for it.

Configuration
REQ-032 Macro PE_ROW_ACC_SAT_EN: defined -> S3 addition saturates to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1] and a 1-bit output sat_flag (registered with data_out, cleared by reset) marks a result where any tile saturated; undefined -> wrap per REQ-028, no sat_flag port.

Verification
REQ-033 Load weights all 1, one vector data_in all 2 with in_last=1, out_ready=1 -> out_valid at T+3, data_out=16 (LANES=8).
REQ-034 Weights lane i = i, three tiles data_in all 1, last on third, back-to-back -> single result 84, out_valid pulses once, no bubbles.
REQ-035 Hold out_ready=0 with a result pending, keep driving last tiles -> in_ready=0 after pipeline fills, data_out stable; release -> results in order, none lost.
REQ-036 w_load_valid and in_valid both high while idle -> weight taken, in_ready=0 that cycle; w_load_valid while tile open -> w_load_ready=0 until last result leaves S3.
REQ-037 ACC_BW=16, weights 127, data -128, 10 tiles -> undefined macro: wrapped value; PE_ROW_ACC_SAT_EN defined: -32768 with sat_flag=1.
REQ-038 Assert rst after two non-last tiles -> all outputs 0; next single last tile with data 1, weights 1 -> data_out=8.
